spi_sub_shift_engine: RTL and testbench
=======================================

# spi_sub_shift_engine

Parametrised SPI subordinate shift engine, the successor to the fixed 8-bit sub shift register pair. It runs entirely in the `pclk` domain and synchronises the raw pad signals `sclk`, `csn` and `simo` internally. It supports all four CPOL/CPHA modes, MSB- or LSB-first ordering and a configurable word width. A one-word TX holding buffer and an RX output register, each with valid/ready handshakes, let the register block exchange back-to-back words within one chip-select frame.

## Interface
- `DATA_WIDTH`, default 8: word width in bits, minimum 2.
- `SYNC_STAGES`, default 2: synchroniser depth for the pad inputs, minimum 2.
- `pclk`  in  1  system clock; all logic is on its rising edge.
- `presetn`  in  1  reset, asynchronous and active-low.
- `cfg_cpol`, `cfg_cpha`, `cfg_lsb_first`  in  1 each  mode controls, latched at frame start.
- `sclk_pad_i`, `csn_pad_i`, `simo_pad_i`  in  1 each  raw SPI pads; `csn_pad_i` is active-low.
- `somi_pad_o`  out  1  serial data out.
- `somi_oe_o`  out  1  output enable for `somi_pad_o`.
- `tx_data`  in  DATA_WIDTH  next word to transmit.
- `tx_valid`  in  1  TX handshake valid.
- `tx_ready`  out  1  TX handshake ready.
- `rx_data`  out  DATA_WIDTH  last received word.
- `rx_valid`  out  1  RX handshake valid.
- `rx_ready`  in  1  RX handshake ready.
- `rx_overrun`  out  1  one-cycle pulse: an unread RX word was overwritten.
- `tx_underrun`  out  1  one-cycle pulse: the shifter was loaded while the TX buffer was empty.
- `busy`  out  1  a frame is active (synchronised CS asserted).

## Operation
- **Synchronisation.** `sclk`, `csn` and `simo` each pass through `SYNC_STAGES` flops. One more flop on `sclk` and `csn` provides edge detection.
- **Frame start.** Occurs on the synchronised `csn` falling edge. At that point:
  - `cfg_*` is latched;
  - `bit_cnt` is set to 0 and `busy` goes to 1;
  - if CPHA=0, the shifter is loaded immediately.
- **Edge definitions.** The leading edge is the rising `sclk` edge when CPOL=0 and the falling edge when CPOL=1.
  - CPHA=0: sample on leading edges, shift on trailing edges.
  - CPHA=1: shift on leading edges, sample on trailing edges.
- **Load rule.** A shift edge with `bit_cnt==0` loads the shifter instead of shifting it. For CPHA=0, the frame-start load replaces the first such edge.
  - If the TX buffer is full, the shifter takes its contents and the buffer empties.
  - If the buffer is empty, the shifter loads all zeros and `tx_underrun` pulses for one cycle.
- **SOMI output.** `somi_pad_o` is shifter bit `DATA_WIDTH-1` for MSB-first and bit 0 for LSB-first. A shift moves the shifter toward the output end and fills with 0.
- **Sample edge.** The synchronised `simo` enters the RX shifter: at the LSB end for MSB-first (shift left), or at the MSB end for LSB-first (shift right). `bit_cnt` then increments.
  - At `DATA_WIDTH-1` it wraps to 0 and the completed word, including the current bit, is written to `rx_data`.
  - `rx_valid` is set on that write.
- **RX handshake.** `rx_valid` stays high until the cycle in which `rx_ready` is high. If a new word completes while `rx_valid=1` and `rx_ready=0`, `rx_data` is overwritten and `rx_overrun` pulses.
- **TX buffer.** `tx_ready` equals NOT(buffer full). A write occurs when `tx_valid & tx_ready`. If a write and a load happen in the same cycle, the load takes the old contents and the buffer stays full with the new word.
- **CPHA=0 frames.** The trailing edge after the last word of the frame commits a buffered word. If CS then deasserts, that word is discarded.
- **Frame end.** Occurs on the synchronised `csn` rising edge, including mid-word. At that point:
  - the partial RX word is discarded;
  - `bit_cnt` is set to 0 and the TX shifter is cleared;
  - `busy` goes to 0;
  - the TX buffer contents are kept.
- **`somi_oe_o`** equals `busy`. `somi_pad_o` is 0 whenever `busy=0`.
- **Idle `sclk`.** Edges on `sclk` while `busy=0` are ignored.
- **Internal states.** IDLE, then ACTIVE on CS fall, then IDLE on CS rise. `bit_cnt` is `$clog2(DATA_WIDTH)` bits wide.

## Timing
- **Reset values.** `somi_pad_o=0`, `somi_oe_o=0`, `tx_ready=1`, `rx_data=0`, `rx_valid=0`, `rx_overrun=0`, `tx_underrun=0`, `busy=0`. All shifters, the buffer and `bit_cnt` are 0.
- **Pad to internal.** An edge at a pad becomes an internal edge event `SYNC_STAGES+1` `pclk` cycles later.
- **RX latency.** `rx_valid` rises one cycle after the internal final sample edge, i.e. `SYNC_STAGES+2` cycles after the pad edge.
- **SOMI latency.** `somi_pad_o` updates one cycle after an internal shift or load event.
- **SCLK limits.** Each `sclk` half-period must be at least `SYNC_STAGES+3` `pclk` cycles, so with defaults `sclk` ≤ `pclk`/10.
- **CS limits.** `csn` setup to the first `sclk` edge must be at least one `sclk` half-period. Same-cycle CS-rise and sample-edge events are resolved in favour of CS rise.
- **Asynchronous reset.** `presetn` low mid-frame forces all reset values immediately.
- **CS re-assertion.** A new frame may begin one cycle after `busy` falls.

## Test plan
- **Mode 0, MSB-first, width 8.** TX=0xA5, master sends 0x3C → SOMI bits 1,0,1,0,0,1,0,1; `rx_data=0x3C`, `rx_valid` held until `rx_ready`.
- **All four modes, LSB-first, width 16.** TX=0x8001, master sends 0x1234 → correct bit order on SOMI each mode; `rx_data=0x1234`.
- **Back-to-back words in one frame.** Buffer 0x11 then 0x22 → both transmitted. `tx_ready` rises after each load. The third word with an empty buffer sends 0x00 and `tx_underrun` pulses once.
- **RX overrun.** Hold `rx_ready=0` across two words 0x55, 0x66 → `rx_data=0x66`, `rx_overrun` is a one-cycle pulse.
- **CS abort.** CS deasserts after 3 bits → no `rx_valid`, `busy=0`, `somi_oe_o=0`. The next frame receives a full correct word.
- **Reset mid-frame.** `presetn` low after 5 bits → all outputs at reset values within the same cycle, `tx_ready=1`.

Source files
------------

// File: rtl/spi_sub_shift_engine_if.sv
// Register-block side of the SPI subordinate shift engine: TX holding buffer
// and RX output register handshakes plus their error pulses.
interface spi_sub_shift_engine_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  rx_overrun;
    logic                  tx_underrun;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid, rx_overrun, tx_underrun
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid, rx_overrun, tx_underrun
    );
endinterface

// File: rtl/spi_sub_shift_engine.sv
// SPI subordinate shift engine running wholly in the pclk domain: pad
// synchronisers, CPOL/CPHA edge decode, TX holding buffer and RX output register.
module spi_sub_shift_engine #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic pclk,
    input  logic presetn,
    input  logic cfg_cpol,
    input  logic cfg_cpha,
    input  logic cfg_lsb_first,
    input  logic sclk_pad_i,
    input  logic csn_pad_i,
    input  logic simo_pad_i,
    output logic somi_pad_o,
    output logic somi_oe_o,
    output logic busy,
    spi_sub_shift_engine_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] sclk_sync, csn_sync, simo_sync;
    logic sclk_d, csn_d;
    logic sclk_s, csn_s, simo_s;
    logic cs_fall, cs_rise, frame_start, frame_end;
    logic lead_edge, trail_edge, sample_ev, shift_ev, load_ev, tx_write;
    logic cpol_q, cpha_q, lsb_q;
    logic [CW-1:0] bit_cnt;
    logic [DATA_WIDTH-1:0] tx_shift, rx_shift, rx_next, buf_q, rx_data_q;
    logic buf_full, rx_valid_q, rx_overrun_q, tx_underrun_q;

    // CS idles high in the synchroniser so a reset release never fakes a frame start.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            sclk_sync <= '0;
            csn_sync  <= '1;
            simo_sync <= '0;
            sclk_d    <= 1'b0;
            csn_d     <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_pad_i};
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], csn_pad_i};
            simo_sync <= {simo_sync[SYNC_STAGES-2:0], simo_pad_i};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            csn_d     <= csn_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cs_fall) state_nx = ACTIVE;
            ACTIVE:  if (cs_rise) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state == ACTIVE);
        somi_oe_o  = (state == ACTIVE);
        somi_pad_o = (state == ACTIVE) & (lsb_q ? tx_shift[0] : tx_shift[DATA_WIDTH-1]);
    end

    // CS rise wins over a coincident sclk edge, so the abort never half-completes a word.
    always_comb begin
        sclk_s      = sclk_sync[SYNC_STAGES-1];
        csn_s       = csn_sync[SYNC_STAGES-1];
        simo_s      = simo_sync[SYNC_STAGES-1];
        cs_fall     = csn_d & ~csn_s;
        cs_rise     = ~csn_d & csn_s;
        frame_start = (state == IDLE) & cs_fall;
        frame_end   = (state == ACTIVE) & cs_rise;
        lead_edge   = cpol_q ? (sclk_d & ~sclk_s) : (~sclk_d & sclk_s);
        trail_edge  = cpol_q ? (~sclk_d & sclk_s) : (sclk_d & ~sclk_s);
        sample_ev   = (state == ACTIVE) & ~cs_rise & (cpha_q ? trail_edge : lead_edge);
        shift_ev    = (state == ACTIVE) & ~cs_rise & (cpha_q ? lead_edge : trail_edge);
        load_ev     = (frame_start & ~cfg_cpha) | (shift_ev & (bit_cnt == '0));
        tx_write    = bus.tx_valid & ~buf_full;
        rx_next     = lsb_q ? {simo_s, rx_shift[DATA_WIDTH-1:1]}
                            : {rx_shift[DATA_WIDTH-2:0], simo_s};
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cpol_q        <= 1'b0;
            cpha_q        <= 1'b0;
            lsb_q         <= 1'b0;
            bit_cnt       <= '0;
            tx_shift      <= '0;
            rx_shift      <= '0;
            buf_q         <= '0;
            buf_full      <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_overrun_q  <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            rx_overrun_q  <= 1'b0;
            tx_underrun_q <= 1'b0;
            if (rx_valid_q && bus.rx_ready) rx_valid_q <= 1'b0;
            if (tx_write) begin
                buf_q    <= bus.tx_data;
                buf_full <= 1'b1;
            end
            if (frame_start) begin
                cpol_q   <= cfg_cpol;
                cpha_q   <= cfg_cpha;
                lsb_q    <= cfg_lsb_first;
                bit_cnt  <= '0;
                rx_shift <= '0;
            end
            if (frame_end) begin
                bit_cnt  <= '0;
                tx_shift <= '0;
                rx_shift <= '0;
            end else if (load_ev) begin
                // A write can only land while the buffer is empty, so it never collides with a full-buffer load.
                if (buf_full) begin
                    tx_shift <= buf_q;
                    buf_full <= 1'b0;
                end else begin
                    tx_shift      <= '0;
                    tx_underrun_q <= 1'b1;
                end
            end else if (shift_ev) begin
                tx_shift <= lsb_q ? (tx_shift >> 1) : (tx_shift << 1);
            end
            if (sample_ev) begin
                rx_shift <= rx_next;
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt    <= '0;
                    rx_data_q  <= rx_next;
                    rx_valid_q <= 1'b1;
                    if (rx_valid_q && !bus.rx_ready) rx_overrun_q <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end
        end
    end

    assign bus.tx_ready    = ~buf_full;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.rx_overrun  = rx_overrun_q;
    assign bus.tx_underrun = tx_underrun_q;
endmodule

// File: tb/tb_spi_sub_shift_engine.sv
// Bench for spi_sub_shift_engine: an 8-bit and a 16-bit instance share the SPI pads,
// each with its own chip select, checked against a word-level TX/RX model.
module tb_spi_sub_shift_engine;
    localparam int SYNC = 2;
    localparam int HALF = 8;

    logic pclk = 1'b0;
    logic presetn = 1'b0;
    logic cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_lsb = 1'b0;
    logic sclk = 1'b0, csn = 1'b1, simo = 1'b0;
    logic sel = 1'b0;
    logic [15:0] tx_data_d = '0;
    logic tx_valid_d = 1'b0, rx_ready_d = 1'b1;

    logic csn8, csn16, somi8, somi16, oe8, oe16, busy8, busy16;
    logic cur_somi, cur_oe, cur_busy, cur_tx_ready, cur_rx_valid, cur_overrun, cur_underrun;
    logic [15:0] cur_rx_data;

    spi_sub_shift_engine_if #(.DATA_WIDTH(8))  bus8();
    spi_sub_shift_engine_if #(.DATA_WIDTH(16)) bus16();

    spi_sub_shift_engine #(.DATA_WIDTH(8), .SYNC_STAGES(SYNC)) u8 (
        .pclk(pclk), .presetn(presetn), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
        .cfg_lsb_first(cfg_lsb), .sclk_pad_i(sclk), .csn_pad_i(csn8), .simo_pad_i(simo),
        .somi_pad_o(somi8), .somi_oe_o(oe8), .busy(busy8), .bus(bus8)
    );

    spi_sub_shift_engine #(.DATA_WIDTH(16), .SYNC_STAGES(SYNC)) u16 (
        .pclk(pclk), .presetn(presetn), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
        .cfg_lsb_first(cfg_lsb), .sclk_pad_i(sclk), .csn_pad_i(csn16), .simo_pad_i(simo),
        .somi_pad_o(somi16), .somi_oe_o(oe16), .busy(busy16), .bus(bus16)
    );

    always #5 pclk = ~pclk;

    assign csn8  = sel ? 1'b1 : csn;
    assign csn16 = sel ? csn : 1'b1;
    assign bus8.tx_data   = tx_data_d[7:0];
    assign bus8.tx_valid  = tx_valid_d & ~sel;
    assign bus8.rx_ready  = rx_ready_d;
    assign bus16.tx_data  = tx_data_d;
    assign bus16.tx_valid = tx_valid_d & sel;
    assign bus16.rx_ready = rx_ready_d;

    assign cur_somi     = sel ? somi16 : somi8;
    assign cur_oe       = sel ? oe16 : oe8;
    assign cur_busy     = sel ? busy16 : busy8;
    assign cur_tx_ready = sel ? bus16.tx_ready : bus8.tx_ready;
    assign cur_rx_valid = sel ? bus16.rx_valid : bus8.rx_valid;
    assign cur_rx_data  = sel ? bus16.rx_data : {8'h00, bus8.rx_data};
    assign cur_overrun  = sel ? bus16.rx_overrun : bus8.rx_overrun;
    assign cur_underrun = sel ? bus16.tx_underrun : bus8.tx_underrun;

    int total = 0;
    int bad = 0;
    int underrun_cnt = 0, overrun_cnt = 0, ready_rise_cnt = 0;
    int exp_underruns;
    logic prev_ready = 1'b1;
    logic [15:0] tx_q8[$], tx_q16[$], model8[$], model16[$];
    logic [15:0] mosi_q[$], miso_words[$], exp_words[$], rx_got[$];

    // Feeder: offers queued TX words to the active instance whenever it is ready.
    always @(negedge pclk) begin
        if (!presetn) tx_valid_d = 1'b0;
        else if (tx_valid_d) tx_valid_d = 1'b0;
        else if (cur_tx_ready) begin
            if (sel && tx_q16.size() > 0) begin
                tx_data_d = tx_q16.pop_front();
                tx_valid_d = 1'b1;
            end else if (!sel && tx_q8.size() > 0) begin
                tx_data_d = tx_q8.pop_front();
                tx_valid_d = 1'b1;
            end
        end
    end

    always @(negedge pclk) begin
        if (cur_underrun) underrun_cnt++;
        if (cur_overrun) overrun_cnt++;
        if (cur_rx_valid && rx_ready_d) rx_got.push_back(cur_rx_data);
        if (cur_tx_ready && !prev_ready) ready_rise_cnt++;
        prev_ready = cur_tx_ready;
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic offer(input logic [15:0] w);
        if (sel) begin
            tx_q16.push_back(w);
            model16.push_back(w);
        end else begin
            tx_q8.push_back(w & 16'h00FF);
            model8.push_back(w & 16'h00FF);
        end
    endtask

    task automatic set_mode(input int m, input logic lsb);
        cfg_cpol = m[1];
        cfg_cpha = m[0];
        cfg_lsb  = lsb;
    endtask

    // Master side of one frame; the model decides which word each load should see.
    task automatic run_frame(input int nbits, input bit keep_cs);
        int w, loads, i, pos;
        logic [15:0] word, obs, v;
        bit have;
        w = sel ? 16 : 8;
        miso_words.delete();
        exp_words.delete();
        rx_got.delete();
        exp_underruns = 0;
        loads = cfg_cpha ? (nbits + w - 1) / w : 1 + nbits / w;
        for (int l = 0; l < loads; l++) begin
            have = sel ? (model16.size() > 0) : (model8.size() > 0);
            v = '0;
            if (have && sel) v = model16.pop_front();
            else if (have) v = model8.pop_front();
            else exp_underruns++;
            if (l < nbits / w) exp_words.push_back(v);
        end
        sclk = cfg_cpol;
        csn = 1'b1;
        cycles(6);
        underrun_cnt = 0;
        overrun_cnt = 0;
        ready_rise_cnt = 0;
        csn = 1'b0;
        cycles(HALF);
        obs = '0;
        for (int b = 0; b < nbits; b++) begin
            i = b % w;
            pos = cfg_lsb ? i : w - 1 - i;
            word = mosi_q[b / w];
            if (i == 0) obs = '0;
            if (!cfg_cpha) begin
                simo = word[pos];
                cycles(HALF);
                sclk = ~cfg_cpol;
                obs[pos] = cur_somi;
                cycles(HALF);
                sclk = cfg_cpol;
            end else begin
                sclk = ~cfg_cpol;
                simo = word[pos];
                cycles(HALF);
                sclk = cfg_cpol;
                obs[pos] = cur_somi;
                cycles(HALF);
            end
            if (i == w - 1) miso_words.push_back(obs);
        end
        if (!keep_cs) begin
            cycles(HALF);
            csn = 1'b1;
            cycles(SYNC + 6);
        end
    endtask

    task automatic test_reset();
        presetn = 1'b0;
        cycles(3);
        presetn = 1'b1;
        cycles(2);
        total++; if (busy8 !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy8); end
        total++; if (oe8 !== 1'b0) begin bad++; $display("[TB] FAIL reset_oe: got %b want 0", oe8); end
        total++; if (somi8 !== 1'b0) begin bad++; $display("[TB] FAIL reset_somi: got %b want 0", somi8); end
        total++; if (bus8.tx_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_tx_ready: got %b want 1", bus8.tx_ready); end
        total++; if (bus8.rx_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_rx_data: got %h want 00", bus8.rx_data); end
        total++; if (bus8.rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rx_valid: got %b want 0", bus8.rx_valid); end
        total++; if (bus8.rx_overrun !== 1'b0 || bus8.tx_underrun !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_pulses: got %b%b want 00", bus8.rx_overrun, bus8.tx_underrun);
        end
        total++; if (busy16 !== 1'b0 || bus16.tx_ready !== 1'b1 || bus16.rx_data !== 16'h0000) begin
            bad++; $display("[TB] FAIL reset_w16: got busy=%b rdy=%b rx=%h want 0 1 0000", busy16, bus16.tx_ready, bus16.rx_data);
        end
    endtask

    task automatic test_mode0_msb();
        sel = 1'b0;
        set_mode(0, 1'b0);
        rx_ready_d = 1'b0;
        offer(16'h00A5);
        mosi_q = '{16'h003C};
        cycles(4);
        run_frame(8, 1'b0);
        total++; if (miso_words.size() != 1 || miso_words[0] !== exp_words[0]) begin
            bad++; $display("[TB] FAIL m0_somi: got %h want %h", miso_words.size() ? miso_words[0] : 16'hxxxx, exp_words[0]);
        end
        total++; if (bus8.rx_data !== 8'h3C || bus8.rx_valid !== 1'b1) begin
            bad++; $display("[TB] FAIL m0_rx: got %h/%b want 3c/1", bus8.rx_data, bus8.rx_valid);
        end
        total++; if (underrun_cnt != exp_underruns) begin
            bad++; $display("[TB] FAIL m0_underrun: got %0d want %0d", underrun_cnt, exp_underruns);
        end
        cycles(10);
        total++; if (bus8.rx_valid !== 1'b1) begin bad++; $display("[TB] FAIL m0_rx_hold: got %b want 1", bus8.rx_valid); end
        rx_ready_d = 1'b1;
        cycles(1);
        total++; if (bus8.rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL m0_rx_clear: got %b want 0", bus8.rx_valid); end
    endtask

    task automatic test_modes_lsb16();
        sel = 1'b1;
        rx_ready_d = 1'b1;
        for (int m = 0; m < 4; m++) begin
            set_mode(m, 1'b1);
            offer(16'h8001);
            mosi_q = '{16'h1234};
            cycles(4);
            run_frame(16, 1'b0);
            total++; if (miso_words.size() != 1 || miso_words[0] !== 16'h8001) begin
                bad++; $display("[TB] FAIL lsb16_somi mode%0d: got %h want 8001", m, miso_words.size() ? miso_words[0] : 16'hxxxx);
            end
            total++; if (rx_got.size() != 1 || rx_got[0] !== 16'h1234) begin
                bad++; $display("[TB] FAIL lsb16_rx mode%0d: got %h (n=%0d) want 1234", m, rx_got.size() ? rx_got[0] : 16'hxxxx, rx_got.size());
            end
        end
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        set_mode(1, 1'b0);
        rx_ready_d = 1'b1;
        offer(16'h0011);
        offer(16'h0022);
        mosi_q = '{16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255))};
        cycles(4);
        run_frame(24, 1'b0);
        for (int k = 0; k < 3; k++) begin
            total++; if (k >= miso_words.size() || miso_words[k] !== exp_words[k]) begin
                bad++; $display("[TB] FAIL b2b_somi word%0d: got %h want %h", k, k < miso_words.size() ? miso_words[k] : 16'hxxxx, exp_words[k]);
            end
            total++; if (k >= rx_got.size() || rx_got[k] !== mosi_q[k]) begin
                bad++; $display("[TB] FAIL b2b_rx word%0d: got %h want %h", k, k < rx_got.size() ? rx_got[k] : 16'hxxxx, mosi_q[k]);
            end
        end
        total++; if (underrun_cnt != 1) begin bad++; $display("[TB] FAIL b2b_underrun: got %0d want 1", underrun_cnt); end
        total++; if (ready_rise_cnt != 2) begin bad++; $display("[TB] FAIL b2b_ready_rises: got %0d want 2", ready_rise_cnt); end
    endtask

    task automatic test_overrun();
        sel = 1'b0;
        set_mode(0, 1'b0);
        rx_ready_d = 1'b0;
        mosi_q = '{16'h0055, 16'h0066};
        run_frame(16, 1'b0);
        total++; if (bus8.rx_data !== 8'h66 || bus8.rx_valid !== 1'b1) begin
            bad++; $display("[TB] FAIL ovr_rx: got %h/%b want 66/1", bus8.rx_data, bus8.rx_valid);
        end
        total++; if (overrun_cnt != 1) begin bad++; $display("[TB] FAIL ovr_pulse: got %0d cycles want 1", overrun_cnt); end
        total++; if (underrun_cnt != exp_underruns) begin
            bad++; $display("[TB] FAIL ovr_underrun: got %0d want %0d", underrun_cnt, exp_underruns);
        end
        rx_ready_d = 1'b1;
        cycles(2);
    endtask

    task automatic test_cs_abort();
        logic [15:0] w2;
        sel = 1'b0;
        set_mode(0, 1'b0);
        rx_ready_d = 1'b1;
        offer(16'($urandom_range(0, 255)));
        mosi_q = '{16'($urandom_range(0, 255))};
        cycles(4);
        run_frame(3, 1'b0);
        total++; if (rx_got.size() != 0) begin bad++; $display("[TB] FAIL abort_rx_valid: got %0d words want 0", rx_got.size()); end
        total++; if (busy8 !== 1'b0 || oe8 !== 1'b0 || somi8 !== 1'b0) begin
            bad++; $display("[TB] FAIL abort_idle: got busy=%b oe=%b somi=%b want 0 0 0", busy8, oe8, somi8);
        end
        w2 = 16'($urandom_range(0, 255)) | 16'h0001;
        offer(16'($urandom_range(0, 255)));
        mosi_q = '{w2};
        cycles(4);
        run_frame(8, 1'b0);
        total++; if (rx_got.size() != 1 || rx_got[0] !== w2) begin
            bad++; $display("[TB] FAIL abort_next_rx: got %h want %h", rx_got.size() ? rx_got[0] : 16'hxxxx, w2);
        end
        total++; if (miso_words.size() != 1 || miso_words[0] !== exp_words[0]) begin
            bad++; $display("[TB] FAIL abort_next_somi: got %h want %h", miso_words.size() ? miso_words[0] : 16'hxxxx, exp_words[0]);
        end
    endtask

    task automatic test_reset_midframe();
        sel = 1'b0;
        set_mode(0, 1'b0);
        offer(16'h00C3);
        offer(16'h005A);
        mosi_q = '{16'h00FF};
        cycles(4);
        run_frame(5, 1'b1);
        total++; if (bus8.tx_ready !== 1'b0 || busy8 !== 1'b1) begin
            bad++; $display("[TB] FAIL midrst_pre: got rdy=%b busy=%b want 0 1", bus8.tx_ready, busy8);
        end
        presetn = 1'b0;
        #1;
        total++; if (busy8 !== 1'b0 || oe8 !== 1'b0 || somi8 !== 1'b0) begin
            bad++; $display("[TB] FAIL midrst_pads: got busy=%b oe=%b somi=%b want 0 0 0", busy8, oe8, somi8);
        end
        total++; if (bus8.tx_ready !== 1'b1 || bus8.rx_valid !== 1'b0 || bus8.rx_data !== 8'h00) begin
            bad++; $display("[TB] FAIL midrst_bus: got rdy=%b vld=%b rx=%h want 1 0 00", bus8.tx_ready, bus8.rx_valid, bus8.rx_data);
        end
        csn = 1'b1;
        sclk = 1'b0;
        tx_q8.delete();
        model8.delete();
        tx_q16.delete();
        model16.delete();
        cycles(3);
        presetn = 1'b1;
        cycles(3);
    endtask

    task automatic test_random();
        int nw, no, w;
        logic [15:0] mask;
        for (int it = 0; it < 8; it++) begin
            sel = 1'($urandom_range(0, 1));
            set_mode(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            rx_ready_d = 1'b1;
            w = sel ? 16 : 8;
            mask = sel ? 16'hFFFF : 16'h00FF;
            nw = int'($urandom_range(1, 3));
            no = int'($urandom_range(0, 3));
            for (int k = 0; k < no; k++) offer(16'($urandom) & mask);
            mosi_q.delete();
            for (int k = 0; k < nw; k++) mosi_q.push_back(16'($urandom) & mask);
            cycles(4);
            run_frame(nw * w, 1'b0);
            for (int k = 0; k < nw; k++) begin
                total++; if (k >= miso_words.size() || miso_words[k] !== exp_words[k]) begin
                    bad++; $display("[TB] FAIL rnd%0d_somi word%0d: got %h want %h", it, k, k < miso_words.size() ? miso_words[k] : 16'hxxxx, exp_words[k]);
                end
                total++; if (k >= rx_got.size() || rx_got[k] !== mosi_q[k]) begin
                    bad++; $display("[TB] FAIL rnd%0d_rx word%0d: got %h want %h", it, k, k < rx_got.size() ? rx_got[k] : 16'hxxxx, mosi_q[k]);
                end
            end
            total++; if (underrun_cnt != exp_underruns) begin
                bad++; $display("[TB] FAIL rnd%0d_underrun: got %0d want %0d", it, underrun_cnt, exp_underruns);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mode0_msb();
        test_modes_lsb16();
        test_back_to_back();
        test_overrun();
        test_cs_abort();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
